// File: rtl/sysbus_arbiter_pkg.sv
// Shared definitions for the Sysbus request arbiter: default widths, FSM state
// type and the requester-ID tag field helpers used on both request and response paths.
package sysbus_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int TAG_WIDTH  = 13;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Helpers work on a 32-bit container so one definition serves any TAG_WIDTH <= 32.
  function automatic logic [31:0] id_field_mask(input int lsb, input int w);
    return ((32'd1 << w) - 32'd1) << lsb;
  endfunction

  function automatic logic [31:0] id_insert(input logic [31:0] tag, input logic [31:0] id,
                                            input int lsb, input int w);
    logic [31:0] mask;
    mask = id_field_mask(lsb, w);
    return (tag & ~mask) | ((id << lsb) & mask);
  endfunction

  function automatic logic [31:0] id_extract(input logic [31:0] tag, input int lsb, input int w);
    return (tag & id_field_mask(lsb, w)) >> lsb;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr_i, wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [IDXW-1:0]  winner_o,
  output logic             valid_o
);

  // Lowest-priority candidates (indices before the pointer) are written first,
  // so the later pass over indices at/after the pointer overrides them.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, otherwise
    // the paths that skip an assignment would infer a latch.
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDXW'(i) < ptr_i)) begin
        winner_o = IDXW'(i);
        valid_o  = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDXW'(i) >= ptr_i)) begin
        winner_o = IDXW'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin, burst-locking arbiter sharing one Sysbus request channel among
// N_REQ clients; responses are routed back by the requester ID stamped in the tag.
module sysbus_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = sysbus_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = sysbus_pkg::TAG_WIDTH,
  parameter int ID_W       = 1,
  parameter int ID_LSB     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ*DATA_WIDTH-1:0] c_req,
  input  logic [N_REQ*TAG_WIDTH-1:0]  c_reqtag,
  input  logic [N_REQ-1:0]            c_reqcyc,
  input  logic [N_REQ-1:0]            c_reqlast,
  output logic [N_REQ-1:0]            c_reqack,
  output logic [DATA_WIDTH-1:0]       c_resp,
  output logic [TAG_WIDTH-1:0]        c_resptag,
  output logic [N_REQ-1:0]            c_respcyc,
  input  logic [N_REQ-1:0]            c_respack,
  output logic [DATA_WIDTH-1:0]       req,
  output logic [TAG_WIDTH-1:0]        reqtag,
  output logic                        reqcyc,
  input  logic                        reqack,
  input  logic [DATA_WIDTH-1:0]       resp,
  input  logic [TAG_WIDTH-1:0]        resptag,
  input  logic                        respcyc,
  output logic                        respack,
  output logic                        err_badid
);

  import sysbus_pkg::arb_state_t;
  import sysbus_pkg::IDLE;
  import sysbus_pkg::BUSY;
  import sysbus_pkg::id_insert;
  import sysbus_pkg::id_extract;

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          state_q, state_d;
  logic [IDXW-1:0]     grant_q, grant_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                err_badid_q, err_badid_d;

  logic [IDXW-1:0]     pick_idx;
  logic                pick_valid;

  logic                sel_cyc;
  logic                sel_last;
  logic [DATA_WIDTH-1:0] sel_req;
  logic [TAG_WIDTH-1:0]  sel_tag;

  logic [31:0]         resp_id;
  logic                resp_bad;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_picker (
    .req_i    (c_reqcyc),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // Granted client's request slice.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_last = 1'b0;
    sel_req  = '0;
    sel_tag  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IDXW'(i)) begin
        sel_cyc  = c_reqcyc[i];
        sel_last = c_reqlast[i];
        sel_req  = c_req[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag  = c_reqtag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Request-side FSM; bus outputs exist only while BUSY, so the async reset
  // (which forces IDLE) silences them at once.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    reqcyc   = 1'b0;
    req      = '0;
    reqtag   = '0;
    c_reqack = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        reqcyc = sel_cyc;
        req    = sel_req;
        reqtag = TAG_WIDTH'(id_insert(32'(sel_tag), 32'(grant_q), ID_LSB, ID_W));
        for (int i = 0; i < N_REQ; i++) begin
          c_reqack[i] = (grant_q == IDXW'(i)) & sel_cyc & reqack;
        end
        if (sel_cyc && reqack && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDXW'(N_REQ - 1)) ? '0 : grant_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response demux; a beat with an out-of-range ID is consumed and flagged.
  always_comb begin
    resp_id     = id_extract(32'(resptag), ID_LSB, ID_W);
    resp_bad    = (resp_id >= 32'(N_REQ));
    c_respcyc   = '0;
    respack     = 1'b0;
    err_badid_d = err_badid_q | (respcyc & resp_bad);
    if (reset) begin
      if (resp_bad) begin
        respack = respcyc;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (resp_id == 32'(i)) begin
            c_respcyc[i] = respcyc;
            respack      = respcyc & c_respack[i];
          end
        end
      end
    end
  end

  assign c_resp    = resp;
  assign c_resptag = resptag;
  assign err_badid = err_badid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      err_badid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      err_badid_q <= err_badid_d;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: directed sequences, response-routing
// vector tables, and randomized traffic against a behavioural arbitration model.
module tb_sysbus_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int N3 = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: N_REQ=2, ID in bit 12
  logic [N*DW-1:0] c_req;
  logic [N*TW-1:0] c_reqtag;
  logic [N-1:0]    c_reqcyc, c_reqlast, c_reqack, c_respcyc, c_respack;
  logic [DW-1:0]   c_resp, req, resp;
  logic [TW-1:0]   c_resptag, reqtag, resptag;
  logic            reqcyc, reqack, respcyc, respack, err_badid;

  // Three-client configuration: ID in bits [12:11]
  logic [N3*DW-1:0] d3_c_req;
  logic [N3*TW-1:0] d3_c_reqtag;
  logic [N3-1:0]    d3_c_reqcyc, d3_c_reqlast, d3_c_reqack, d3_c_respcyc, d3_c_respack;
  logic [DW-1:0]    d3_c_resp, d3_req, d3_resp;
  logic [TW-1:0]    d3_c_resptag, d3_reqtag, d3_resptag;
  logic             d3_reqcyc, d3_reqack, d3_respcyc, d3_respack, d3_err_badid;

  sysbus_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ID_W(1), .ID_LSB(12)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_reqtag(c_reqtag), .c_reqcyc(c_reqcyc), .c_reqlast(c_reqlast),
    .c_reqack(c_reqack), .c_resp(c_resp), .c_resptag(c_resptag), .c_respcyc(c_respcyc),
    .c_respack(c_respack), .req(req), .reqtag(reqtag), .reqcyc(reqcyc), .reqack(reqack),
    .resp(resp), .resptag(resptag), .respcyc(respcyc), .respack(respack),
    .err_badid(err_badid)
  );

  sysbus_arbiter #(.N_REQ(N3), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ID_W(2), .ID_LSB(11)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(d3_c_req), .c_reqtag(d3_c_reqtag), .c_reqcyc(d3_c_reqcyc), .c_reqlast(d3_c_reqlast),
    .c_reqack(d3_c_reqack), .c_resp(d3_c_resp), .c_resptag(d3_c_resptag),
    .c_respcyc(d3_c_respcyc), .c_respack(d3_c_respack), .req(d3_req), .reqtag(d3_reqtag),
    .reqcyc(d3_reqcyc), .reqack(d3_reqack), .resp(d3_resp), .resptag(d3_resptag),
    .respcyc(d3_respcyc), .respack(d3_respack), .err_badid(d3_err_badid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    c_req = '0; c_reqtag = '0; c_reqcyc = '0; c_reqlast = '0; c_respack = '0;
    reqack = 1'b0; resp = '0; resptag = '0; respcyc = 1'b0;
    d3_c_req = '0; d3_c_reqtag = '0; d3_c_reqcyc = '0; d3_c_reqlast = '0; d3_c_respack = '0;
    d3_reqack = 1'b0; d3_resp = '0; d3_resptag = '0; d3_respcyc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        respcyc;
    logic [12:0] tag;
    logic [2:0]  ack;
    logic [2:0]  exp_cyc;
    logic        exp_ack;
  } rt_vec_t;

  rt_vec_t rt2[5];
  rt_vec_t rt3[5];

  // Behavioural model state for the random phase
  int owner;
  int ptr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_reqcyc, exp_rack;
    logic [DW-1:0] exp_req;
    logic [TW-1:0] exp_tag;
    logic [N-1:0]  exp_ack, exp_rcyc;
    int beats, cyc, id;
    logic ack_t, found;

    // Response-routing vectors: {respcyc, resptag, c_respack, expected c_respcyc, expected respack}
    rt2[0] = '{1'b1, 13'h1005, 3'b000, 3'b010, 1'b0};
    rt2[1] = '{1'b1, 13'h1005, 3'b010, 3'b010, 1'b1};
    rt2[2] = '{1'b1, 13'h0005, 3'b001, 3'b001, 1'b1};
    rt2[3] = '{1'b1, 13'h0005, 3'b010, 3'b001, 1'b0};
    rt2[4] = '{1'b0, 13'h1005, 3'b011, 3'b000, 1'b0};
    rt3[0] = '{1'b1, 13'h0010, 3'b001, 3'b001, 1'b1};
    rt3[1] = '{1'b1, 13'h1010, 3'b011, 3'b100, 1'b0};
    rt3[2] = '{1'b1, 13'h0810, 3'b010, 3'b010, 1'b1};
    rt3[3] = '{1'b1, 13'h1810, 3'b111, 3'b000, 1'b1};
    rt3[4] = '{1'b0, 13'h1810, 3'b111, 3'b000, 1'b0};

    // Reset state while every input is active
    clear_inputs();
    reset = 1'b0;
    c_reqcyc = '1; c_reqlast = '1; reqack = 1'b1;
    respcyc = 1'b1; resptag = 13'h1005; c_respack = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reqcyc", reqcyc, 0);
    check("rst_c_reqack", c_reqack, 0);
    check("rst_c_respcyc", c_respcyc, 0);
    check("rst_respack", respack, 0);
    check("rst_err_badid", err_badid, 0);

    // Single client, one beat
    do_reset();
    c_req[0 +: DW] = 64'h1111_2222_3333_4444;
    c_reqtag[0 +: TW] = 13'h0ABC;
    c_reqcyc = 2'b01; c_reqlast = 2'b01; reqack = 1'b1;
    #1;
    check("single_latency_reqcyc", reqcyc, 0);
    tick();
    check("single_reqcyc", reqcyc, 1);
    check("single_reqtag", reqtag, 13'h0ABC);
    check("single_req", req, 64'h1111_2222_3333_4444);
    check("single_c_reqack", c_reqack, 2'b01);
    tick();
    check("single_idle_reqcyc", reqcyc, 0);
    check("single_idle_c_reqack", c_reqack, 0);
    c_reqcyc = 2'b00;
    tick();
    check("single_stays_idle", reqcyc, 0);

    // Contention fairness with continuous single-beat requests
    do_reset();
    c_req[0 +: DW] = 64'hA0A0_A0A0_0000_0000;
    c_req[DW +: DW] = 64'hB1B1_B1B1_1111_1111;
    c_reqtag[0 +: TW] = 13'h1234;
    c_reqtag[TW +: TW] = 13'h0234;
    c_reqcyc = 2'b11; c_reqlast = 2'b11; reqack = 1'b1;
    #1;
    check("fair_first_idle", reqcyc, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        int o;
        o = ((k - 1) / 2) % 2;
        check("fair_reqcyc", reqcyc, 1);
        check("fair_c_reqack", c_reqack, (o == 0) ? 2'b01 : 2'b10);
        check("fair_reqtag", reqtag, (o == 0) ? 13'h0234 : 13'h1234);
        check("fair_req", req, (o == 0) ? 64'hA0A0_A0A0_0000_0000 : 64'hB1B1_B1B1_1111_1111);
      end else begin
        check("fair_bubble_reqcyc", reqcyc, 0);
        check("fair_bubble_c_reqack", c_reqack, 0);
      end
    end

    // Burst lock: client 1 four beats with toggling reqack, client 0 waiting
    do_reset();
    c_req[DW +: DW] = 64'hDEAD_BEEF_0000_0001;
    c_reqtag[TW +: TW] = 13'h0ABC;
    c_reqtag[0 +: TW] = 13'h1555;
    c_reqcyc = 2'b10;
    tick();
    c_reqcyc = 2'b11;
    c_reqlast[0] = 1'b1;
    beats = 0; cyc = 0; ack_t = 1'b1;
    while (beats < 4 && cyc < 20) begin
      reqack = ack_t;
      c_reqlast[1] = (beats == 3);
      #1;
      check("lock_reqcyc", reqcyc, 1);
      check("lock_c_reqack", c_reqack, ack_t ? 2'b10 : 2'b00);
      check("lock_reqtag", reqtag, 13'h1ABC);
      if (ack_t) beats++;
      ack_t = ~ack_t;
      cyc++;
      tick();
    end
    check("lock_beats", beats, 4);
    check("lock_cycles", cyc, 7);
    reqack = 1'b1;
    #1;
    check("lock_bubble_reqcyc", reqcyc, 0);
    check("lock_bubble_c_reqack", c_reqack, 0);
    tick();
    check("lock_next_c_reqack", c_reqack, 2'b01);
    check("lock_next_reqtag", reqtag, 13'h0555);

    // Reset mid-burst, rr pointer returns to 0
    do_reset();
    c_reqtag[0 +: TW] = 13'h1111;
    c_reqtag[TW +: TW] = 13'h0ABC;
    c_reqcyc = 2'b01; c_reqlast = 2'b01; reqack = 1'b1;
    tick();
    tick();
    c_reqcyc = 2'b10; c_reqlast = 2'b00;
    tick();
    tick();
    check("midrst_beat2_reqcyc", reqcyc, 1);
    check("midrst_beat2_c_reqack", c_reqack, 2'b10);
    reset = 1'b0;
    c_reqcyc = 2'b11; c_reqlast = 2'b11;
    #1;
    check("midrst_reqcyc_drop", reqcyc, 0);
    check("midrst_c_reqack_drop", c_reqack, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("midrst_ptr0_c_reqack", c_reqack, 2'b01);
    check("midrst_ptr0_reqtag", reqtag, 13'h0111);
    do_reset();
    c_reqtag[TW +: TW] = 13'h0ABC;
    c_reqcyc = 2'b10; c_reqlast = 2'b10; reqack = 1'b1;
    tick();
    check("postrst_c1_c_reqack", c_reqack, 2'b10);
    check("postrst_c1_reqtag", reqtag, 13'h1ABC);

    // Response-routing tables
    do_reset();
    foreach (rt2[i]) begin
      resp = {$urandom, $urandom};
      resptag = rt2[i].tag; respcyc = rt2[i].respcyc; c_respack = rt2[i].ack[N-1:0];
      #1;
      check("route2_c_respcyc", c_respcyc, rt2[i].exp_cyc);
      check("route2_respack", respack, rt2[i].exp_ack);
      check("route2_c_resptag", c_resptag, rt2[i].tag);
      check("route2_c_resp", c_resp, resp);
    end
    foreach (rt3[i]) begin
      d3_resptag = rt3[i].tag; d3_respcyc = rt3[i].respcyc; d3_c_respack = rt3[i].ack;
      #1;
      check("route3_c_respcyc", d3_c_respcyc, rt3[i].exp_cyc);
      check("route3_respack", d3_respack, rt3[i].exp_ack);
    end

    // Sticky bad-ID flag
    do_reset();
    d3_resptag = 13'h1810; d3_respcyc = 1'b0;
    #1;
    check("badid_init", d3_err_badid, 0);
    tick();
    check("badid_no_cyc", d3_err_badid, 0);
    d3_respcyc = 1'b1;
    #1;
    check("badid_respack", d3_respack, 1);
    check("badid_c_respcyc", d3_c_respcyc, 0);
    check("badid_not_yet", d3_err_badid, 0);
    tick();
    check("badid_set", d3_err_badid, 1);
    d3_resptag = 13'h0010; d3_c_respack = 3'b001;
    repeat (3) tick();
    check("badid_sticky", d3_err_badid, 1);
    reset = 1'b0;
    #1;
    check("badid_cleared_by_reset", d3_err_badid, 0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the behavioural model
    do_reset();
    owner = -1;
    ptr = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++) begin
        c_req[c*DW +: DW] = {$urandom, $urandom};
        c_reqtag[c*TW +: TW] = TW'($urandom);
        c_reqlast[c] = ($urandom_range(0, 2) == 0);
      end
      c_reqcyc  = N'($urandom_range(0, 3));
      reqack    = 1'($urandom_range(0, 1));
      c_respack = N'($urandom_range(0, 3));
      respcyc   = 1'($urandom_range(0, 1));
      resptag   = TW'($urandom);
      resp      = {$urandom, $urandom};
      #1;
      if (owner < 0) begin
        exp_reqcyc = 1'b0; exp_req = '0; exp_tag = '0; exp_ack = '0;
      end else begin
        exp_reqcyc = 1'((c_reqcyc >> owner) & 1);
        exp_req    = DW'(c_req >> (owner * DW));
        exp_tag    = TW'(c_reqtag >> (owner * TW));
        exp_tag[12] = (owner == 1);
        exp_ack    = (exp_reqcyc && reqack) ? N'(1 << owner) : '0;
      end
      id = int'(resptag[12]);
      exp_rcyc = respcyc ? N'(1 << id) : '0;
      exp_rack = respcyc & 1'((c_respack >> id) & 1);
      check("rnd_reqcyc", reqcyc, exp_reqcyc);
      check("rnd_req", req, exp_req);
      check("rnd_reqtag", reqtag, exp_tag);
      check("rnd_c_reqack", c_reqack, exp_ack);
      check("rnd_c_respcyc", c_respcyc, exp_rcyc);
      check("rnd_respack", respack, exp_rack);
      check("rnd_c_resp", c_resp, resp);
      check("rnd_c_resptag", c_resptag, resptag);
      check("rnd_err_badid", err_badid, 0);
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (ptr + k) % N;
          if (!found && ((c_reqcyc >> c) & 1) != 0) begin
            owner = c;
            found = 1'b1;
          end
        end
      end else if (exp_reqcyc && reqack && ((c_reqlast >> owner) & 1) != 0) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
